// File: rtl/spi_xfer_pkg.sv
// Shared state encoding and parameter defaults for the SPI transfer controller.
package spi_xfer_pkg;

  localparam int unsigned SPI_XFER_DEPTH_DEF   = 4;
  localparam int unsigned SPI_XFER_TIMEOUT_DEF = 256;
  localparam int unsigned SPI_XFER_BYTE_W      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } spi_xfer_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop and a push in one cycle both succeed.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Byte-stream front end for an SPI master: TX/RX FIFOs plus a launch/wait sequencer.
// Optional WAIT-state abort timer enabled by defining SPI_XFER_TIMEOUT_EN.
module spi_xfer_ctrl
  import spi_xfer_pkg::*;
#(
  parameter int unsigned DEPTH   = SPI_XFER_DEPTH_DEF,
  parameter int unsigned TIMEOUT = SPI_XFER_TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  input  logic [SPI_XFER_BYTE_W-1:0]  s_data,
  output logic                        s_ready,
  output logic                        m_valid,
  output logic [SPI_XFER_BYTE_W-1:0]  m_data,
  input  logic                        m_ready,
  output logic                        spi_start,
  output logic [SPI_XFER_BYTE_W-1:0]  spi_tx_data,
  input  logic                        spi_busy,
  input  logic                        spi_done,
  input  logic [SPI_XFER_BYTE_W-1:0]  spi_rx_data,
  output logic [$clog2(DEPTH):0]      tx_count,
  output logic [$clog2(DEPTH):0]      rx_count,
  output logic                        idle,
  output logic                        timeout_err
);

  localparam int unsigned BW = SPI_XFER_BYTE_W;

  spi_xfer_state_e state_q, state_d;
  logic            start_q, start_d;
  logic [BW-1:0]   tx_data_q, tx_data_d;

  logic          tx_full, tx_empty, tx_pop;
  logic [BW-1:0] tx_head;
  logic          rx_full, rx_empty, rx_push;
  logic [BW-1:0] rx_push_data;
  logic          tmo_hit;

  sync_fifo #(.WIDTH(BW), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s_valid && !tx_full),
    .push_data (s_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  sync_fifo #(.WIDTH(BW), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (m_ready && !rx_empty),
    .pop_data  (m_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  assign s_ready     = !tx_full;
  assign m_valid     = !rx_empty;
  assign idle        = (state_q == IDLE) && tx_empty;
  assign spi_start   = start_q;
  assign spi_tx_data = tx_data_q;

`ifdef SPI_XFER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_err_q, tmo_err_d;

  // Counter restarts on every entry to WAIT; fires on the TIMEOUT-th WAIT cycle without done.
  assign tmo_hit     = (state_q == WAIT) && !spi_done && (tmo_cnt_q == TW'(TIMEOUT - 1));
  assign tmo_cnt_d   = (state_q == WAIT) ? tmo_cnt_q + TW'(1) : '0;
  assign tmo_err_d   = tmo_err_q || tmo_hit;
  assign timeout_err = tmo_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end
`else
  logic unused_timeout;

  assign tmo_hit        = 1'b0;
  assign timeout_err    = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

  // Launch only when the returning byte is guaranteed an RX slot.
  always_comb begin
    state_d      = state_q;
    start_d      = 1'b0;
    tx_data_d    = tx_data_q;
    tx_pop       = 1'b0;
    rx_push      = 1'b0;
    rx_push_data = spi_rx_data;
    unique case (state_q)
      IDLE: begin
        if (!tx_empty && !rx_full && !spi_busy) begin
          state_d   = LAUNCH;
          start_d   = 1'b1;
          tx_data_d = tx_head;
        end
      end
      LAUNCH: begin
        tx_pop  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (spi_done) begin
          rx_push = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          rx_push      = 1'b1;
          rx_push_data = 8'hFF;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      tx_data_q <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl with a behavioural SPI master and random host traffic.
module tb_spi_xfer_ctrl;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  typedef enum int { M_LOOP, M_XOR, M_TMO } mode_e;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, m_ready;
  logic [7:0]    s_data;
  logic          s_ready, m_valid;
  logic [7:0]    m_data;
  logic          spi_start;
  logic [7:0]    spi_tx_data;
  logic          spi_busy, spi_done;
  logic [7:0]    spi_rx_data;
  logic [CW-1:0] tx_count, rx_count;
  logic          idle, timeout_err;

  logic       pend, hold_busy, hold_done, spur_en;
  int         lat;
  logic [7:0] cap;
  mode_e      mode;
  logic [7:0] exp_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         starts   = 0;
  int         pops     = 0;
  int         s0, p0, t;

  assign spi_busy = pend | hold_busy;

  spi_xfer_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .spi_start   (spi_start),
    .spi_tx_data (spi_tx_data),
    .spi_busy    (spi_busy),
    .spi_done    (spi_done),
    .spi_rx_data (spi_rx_data),
    .tx_count    (tx_count),
    .rx_count    (rx_count),
    .idle        (idle),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xform(input logic [7:0] b);
    case (mode)
      M_LOOP:  return b;
      M_XOR:   return b ^ 8'h5A;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit drained();
    return idle && (rx_count == '0) && (exp_q.size() == 0) && !pend;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int k = 0;
    while (spi_start !== 1'b1 && k < 20) begin step(); k++; end
    check(name, 32'(spi_start), 32'd1);
  endtask

  task automatic wait_drained(input string name, input int bound);
    int k = 0;
    while (!drained() && k < bound) begin step(); k++; end
    check(name, 32'(drained()), 32'd1);
  endtask

  // Behavioural SPI master: accepts a start, finishes after a random latency.
  initial begin
    pend = 1'b0; lat = 0; cap = '0; spi_done = 1'b0; spi_rx_data = '0;
    forever begin
      step();
      spi_done = 1'b0;
      if (spi_start === 1'b1) begin
        check("start_while_master_busy", 32'(pend), 32'd0);
        starts++;
        cap  = spi_tx_data;
        pend = 1'b1;
        lat  = int'($urandom_range(0, 5));
      end else if (pend) begin
        if (!hold_done) begin
          if (lat == 0) begin
            spi_done    = 1'b1;
            spi_rx_data = xform(cap);
            pend        = 1'b0;
          end else begin
            lat--;
          end
        end
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        spi_done    = 1'b1;
        spi_rx_data = 8'($urandom);
      end
    end
  end

  // Monitor: record accepted host bytes, compare every RX pop in order.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (s_valid && s_ready) exp_q.push_back(xform(s_data));
        if (m_valid && m_ready) begin
          pops++;
          if (exp_q.size() == 0) check("rx_unexpected_byte", 32'(m_data), 32'hFFFF_FFFF);
          else                   check("rx_byte_order", 32'(m_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    hold_busy = 1'b0; hold_done = 1'b0; spur_en = 1'b0; mode = M_LOOP;
    repeat (3) step();
    check("rst_s_ready",  32'(s_ready),     32'd1);
    check("rst_m_valid",  32'(m_valid),     32'd0);
    check("rst_idle",     32'(idle),        32'd1);
    check("rst_start",    32'(spi_start),   32'd0);
    check("rst_tx_data",  32'(spi_tx_data), 32'd0);
    check("rst_tx_count", 32'(tx_count),    32'd0);
    check("rst_rx_count", 32'(rx_count),    32'd0);
    check("rst_tmo_err",  32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    step();

    // Single loopback byte.
    s0 = starts;
    push_byte(8'hA5);
    t = 0;
    while (!m_valid && t < 30) begin step(); t++; end
    check("a5_m_valid", 32'(m_valid),     32'd1);
    check("a5_m_data",  32'(m_data),      32'hA5);
    check("a5_starts",  32'(starts - s0), 32'd1);
    check("a5_tx_hold", 32'(spi_tx_data), 32'hA5);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("a5_rx_empty", 32'(rx_count), 32'd0);

    // Fill TX with the master stalled; the fifth byte must be refused.
    mode = M_XOR;
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
    check("full_tx_count", 32'(tx_count), 32'd4);
    check("full_s_ready",  32'(s_ready),  32'd0);
    check("full_not_idle", 32'(idle),     32'd0);
    hold_busy = 1'b0;
    m_ready = 1'b1;
    p0 = pops;
    wait_drained("full_drain", 200);
    check("full_pop_count", 32'(pops - p0), 32'd4);
    m_ready = 1'b0;

    // RX back-pressure: fifth byte waits for one RX slot.
    for (int i = 0; i < 4; i++) push_byte(8'h20 + 8'(i));
    t = 0;
    while (rx_count != CW'(4) && t < 100) begin step(); t++; end
    check("bp_rx_full", 32'(rx_count), 32'd4);
    s0 = starts;
    push_byte(8'h24);
    repeat (20) step();
    check("bp_rx_hold",   32'(rx_count),    32'd4);
    check("bp_tx_wait",   32'(tx_count),    32'd1);
    check("bp_no_launch", 32'(starts - s0), 32'd0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    t = 0;
    while (!(rx_count == CW'(4) && tx_count == '0 && !pend) && t < 50) begin step(); t++; end
    check("bp_one_launch", 32'(starts - s0), 32'd1);
    check("bp_rx_refill",  32'(rx_count),    32'd4);
    m_ready = 1'b1;
    wait_drained("bp_drain", 200);
    m_ready = 1'b0;

    // Host push lands in the same cycle as the TX pop.
    hold_busy = 1'b1;
    push_byte(8'h31);
    push_byte(8'h32);
    check("pp_pre_count", 32'(tx_count), 32'd2);
    hold_busy = 1'b0;
    wait_start("pp_launch");
    check("pp_launch_count", 32'(tx_count), 32'd2);
    push_byte(8'h33);
    check("pp_post_count", 32'(tx_count), 32'd2);
    m_ready = 1'b1;
    wait_drained("pp_drain", 200);
    m_ready = 1'b0;

    // Reset in the middle of WAIT; the late done must not reach RX.
    hold_done = 1'b1;
    push_byte(8'h77);
    wait_start("mid_launch");
    push_byte(8'h78);
    step();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_start",    32'(spi_start),   32'd0);
    check("mid_tx_data",  32'(spi_tx_data), 32'd0);
    check("mid_tx_count", 32'(tx_count),    32'd0);
    check("mid_rx_count", 32'(rx_count),    32'd0);
    check("mid_s_ready",  32'(s_ready),     32'd1);
    check("mid_m_valid",  32'(m_valid),     32'd0);
    check("mid_idle",     32'(idle),        32'd1);
    check("mid_tmo_err",  32'(timeout_err), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    s0 = starts;
    hold_done = 1'b0;
    t = 0;
    while (pend && t < 20) begin step(); t++; end
    repeat (3) step();
    check("late_done_rx_count", 32'(rx_count),    32'd0);
    check("late_done_m_valid",  32'(m_valid),     32'd0);
    check("late_done_idle",     32'(idle),        32'd1);
    check("late_done_starts",   32'(starts - s0), 32'd0);

`ifdef SPI_XFER_TIMEOUT_EN
    // Master never answers: abort after TIMEOUT WAIT cycles.
    mode = M_TMO;
    hold_done = 1'b1;
    push_byte(8'h5C);
    wait_start("tmo_launch");
    t = 0;
    while (rx_count == '0 && t < 40) begin step(); t++; end
    check("tmo_cycles",   32'(t),           32'(TIMEOUT + 1));
    check("tmo_rx_count", 32'(rx_count),    32'd1);
    check("tmo_m_data",   32'(m_data),      32'hFF);
    check("tmo_err",      32'(timeout_err), 32'd1);
    check("tmo_idle",     32'(idle),        32'd1);
    hold_done = 1'b0;
    t = 0;
    while (pend && t < 20) begin step(); t++; end
    step();
    m_ready = 1'b1;
    wait_drained("tmo_drain", 50);
    m_ready = 1'b0;
    check("tmo_err_sticky", 32'(timeout_err), 32'd1);
`else
    // Without the timer WAIT holds until done arrives.
    hold_done = 1'b1;
    push_byte(8'h5C);
    wait_start("notmo_launch");
    repeat (40) step();
    check("notmo_rx_count", 32'(rx_count),    32'd0);
    check("notmo_err",      32'(timeout_err), 32'd0);
    check("notmo_waiting",  32'(idle),        32'd0);
    hold_done = 1'b0;
    m_ready = 1'b1;
    wait_drained("notmo_drain", 50);
    m_ready = 1'b0;
`endif

    // Random traffic with spurious done pulses outside WAIT.
    mode = M_XOR;
    spur_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      s_valid = ($urandom_range(0, 1) == 1);
      s_data  = 8'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    s_valid = 1'b0;
    spur_en = 1'b0;
    m_ready = 1'b1;
    wait_drained("rand_drain", 400);
    check("rand_exp_empty", 32'(exp_q.size()), 32'd0);
    check("rand_tx_count",  32'(tx_count),     32'd0);
    check("rand_idle",      32'(idle),         32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entries per TX and RX FIFO (power of 2, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 256, meaning the maximum cycles from start to done before abort (used only under REQ-026).
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 s_valid / s_data / s_ready  in / in[8] / out  host TX byte push; transfer on valid&&ready.
REQ-006 m_valid / m_data / m_ready  out / out[8] / in  host RX byte pop; transfer on valid&&ready.
REQ-007 spi_start / spi_tx_data  out / out[8]  connect to the SPI master start and tx_data inputs.
REQ-008 spi_busy / spi_done / spi_rx_data  in / in / in[8]  connect to the SPI master status outputs.
REQ-009 tx_count / rx_count  out / out[$clog2(DEPTH)+1]  FIFO occupancy.
REQ-010 idle  out  1  high when FSM is IDLE and TX FIFO is empty.
REQ-011 timeout_err  out  1  sticky abort flag.

Function
REQ-012 SHALL buffer host bytes in a TX FIFO; s_ready = (tx_count != DEPTH).
REQ-013 SHALL buffer received bytes in an RX FIFO; m_valid = (rx_count != 0); m_data = RX head, valid in the same cycle as m_valid.
REQ-014 FSM states: IDLE, LAUNCH, WAIT.
REQ-015 IDLE->LAUNCH when TX is non-empty, RX has space counting the byte in flight, and spi_busy=0.
REQ-016 LAUNCH (1 cycle): spi_start=1, spi_tx_data=TX head, TX pop; then ->WAIT.
REQ-017 WAIT: on spi_done=1, push spi_rx_data into RX and go ->IDLE.
REQ-018 spi_start SHALL be a registered output, high exactly one cycle per byte; spi_tx_data holds its value until the next LAUNCH.
REQ-019 Minimum spacing: next LAUNCH no earlier than the cycle after the done cycle.
REQ-020 Push and pop in the same cycle on one FIFO: count unchanged, both operations succeed.
REQ-021 Host push into a full TX FIFO and pop from an empty RX FIFO SHALL be ignored; no state change.
REQ-022 Pointers wrap modulo DEPTH; count distinguishes full from empty.
REQ-023 spi_done seen outside WAIT SHALL be ignored.

Reset
REQ-024 On rst_n=0 (asynchronous, including mid-transfer): FSM=IDLE, both FIFOs empty, spi_start=0, spi_tx_data=0, timeout_err=0, m_valid=0, s_ready=1, idle=1.
REQ-025 A byte in flight at reset SHALL be discarded; its done is ignored per REQ-023.

Configuration
REQ-026 With SPI_XFER_TIMEOUT_EN defined: a counter runs in WAIT; if TIMEOUT cycles elapse without done, push 8'hFF to RX, set timeout_err (cleared only by reset), ->IDLE.
REQ-027 Without SPI_XFER_TIMEOUT_EN: WAIT lasts indefinitely; timeout_err is tied to 0; no counter is synthesized.

Structure
REQ-028 Package spi_xfer_pkg SHALL hold the state enum (IDLE/LAUNCH/WAIT), SPI_XFER_DEPTH_DEF=4 and SPI_XFER_TIMEOUT_DEF=256.
REQ-029 SHALL instantiate sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count) twice, for TX and RX.

Verification
REQ-030 Push 8'hA5 with the SPI master in loopback (mosi->miso) -> exactly one spi_start pulse carrying A5; after done, m_data=A5 with m_valid=1.
REQ-031 Push 5 bytes at DEPTH=4 with the master stalled -> s_ready=0 after 4 bytes and the 5th is ignored; after drain, bytes come out in order 4 times.
REQ-032 Hold m_ready=0, send 4 bytes, push a 5th -> 5th not launched until one RX pop; no RX overflow.
REQ-033 Assert rst_n=0 mid-WAIT -> all outputs at reset values next cycle; late spi_done produces no RX entry.
REQ-034 With SPI_XFER_TIMEOUT_EN and TIMEOUT=16, never assert done -> after 16 WAIT cycles, RX holds FF, timeout_err=1, FSM IDLE.
REQ-035 Simultaneous host push and TX pop at tx_count=2 -> tx_count stays 2.
